// File: rtl/mem_arbiter_n.sv
// -----------------------------------------------------------------------------
// mem_arbiter_n
//
// Merges NUM_PORTS memory requesters (instruction fetch, data, DMA, debug)
// onto one downstream memory bus using the access/ack handshake, word
// addressing [ADDR_WIDTH:1] and byte selects.
//
// In IDLE the winning requester is chosen combinationally and driven straight
// onto the downstream bus. The arbiter then locks onto that port (BUSY) until
// the slave acks or the port withdraws its request.
//
// Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN
//   defined   : round-robin arbitration starting after the last granted port
//   undefined : fixed priority, highest port index wins (no pointer register)
//
// Ports (port-indexed buses are flattened, port i at slice i):
//   clk, reset      clock, asynchronous active-high reset
//   m_addr          requester word addresses        (NUM_PORTS*ADDR_WIDTH)
//   m_data_out      requester write data            (NUM_PORTS*DATA_WIDTH)
//   m_data_in       read data, zero on non-granted  (NUM_PORTS*DATA_WIDTH)
//   m_access        request strobes                 (NUM_PORTS)
//   m_ack           per-port completion             (NUM_PORTS)
//   m_wr_en         write enables                   (NUM_PORTS)
//   m_bytesel       byte selects                    (NUM_PORTS*BYTESEL_WIDTH)
//   q_m_*           downstream bus (addr, data in/out, access, ack, wr_en,
//                   bytesel)
//   q_grant         one-hot bus owner, zero when nothing is requested
// -----------------------------------------------------------------------------
module mem_arbiter_n #(
   parameter int  NUM_PORTS     = 4,
   parameter int  ADDR_WIDTH    = 19,
   parameter int  DATA_WIDTH    = 16,
   localparam int BYTESEL_WIDTH = DATA_WIDTH / 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    m_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]    m_data_out,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]    m_data_in,
   input  logic [NUM_PORTS-1:0]               m_access,
   output logic [NUM_PORTS-1:0]               m_ack,
   input  logic [NUM_PORTS-1:0]               m_wr_en,
   input  logic [NUM_PORTS*BYTESEL_WIDTH-1:0] m_bytesel,
   output logic [ADDR_WIDTH-1:0]              q_m_addr,
   input  logic [DATA_WIDTH-1:0]              q_m_data_in,
   output logic [DATA_WIDTH-1:0]              q_m_data_out,
   output logic                               q_m_access,
   input  logic                               q_m_ack,
   output logic                               q_m_wr_en,
   output logic [BYTESEL_WIDTH-1:0]           q_m_bytesel,
   output logic [NUM_PORTS-1:0]               q_grant
);

   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   grant_idx_q, grant_idx_d;
   logic [IW-1:0]   win_s;
   logic [IW-1:0]   sel_s;
   logic            any_req_s;
   logic            busy_s;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic [IW-1:0]   last_grant_q, last_grant_d;
`endif

   assign any_req_s = |m_access;
   assign busy_s    = (state_q == ST_BUSY);
   // Locked to the registered owner while BUSY, otherwise follow the live winner.
   assign sel_s     = busy_s ? grant_idx_q : win_s;

   // Winner selection among the current requesters.
   always_comb begin
      win_s = '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      begin
         logic found;
         int   cand;
         found = 1'b0;
         // Search starts one past the last grant and wraps around.
         for (int k = 1; k <= NUM_PORTS; k++) begin
            cand  = (int'(last_grant_q) + k) % NUM_PORTS;
            win_s = (!found && m_access[cand]) ? IW'(cand) : win_s;
            found = found | m_access[cand];
         end
      end
`else
      // Later (higher) indices overwrite earlier ones: highest index wins.
      for (int i = 0; i < NUM_PORTS; i++) begin
         win_s = m_access[i] ? IW'(i) : win_s;
      end
`endif
   end

   // Downstream mux; the strobe drops in the ack cycle and on abandon.
   always_comb begin
      q_m_addr     = m_addr[int'(sel_s)*ADDR_WIDTH +: ADDR_WIDTH];
      q_m_data_out = m_data_out[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
      q_m_bytesel  = m_bytesel[int'(sel_s)*BYTESEL_WIDTH +: BYTESEL_WIDTH];
      q_m_wr_en    = m_wr_en[sel_s];
      q_m_access   = ~q_m_ack & (busy_s ? m_access[grant_idx_q] : any_req_s);
   end

   // Per-port return path and one-hot grant.
   always_comb begin
      m_data_in = '0;
      m_ack     = '0;
      q_grant   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         m_data_in[i*DATA_WIDTH +: DATA_WIDTH] =
            (busy_s && (grant_idx_q == IW'(i))) ? q_m_data_in : '0;
         m_ack[i]   = busy_s & (grant_idx_q == IW'(i)) & q_m_ack;
         q_grant[i] = busy_s ? (grant_idx_q == IW'(i))
                             : (any_req_s & (win_s == IW'(i)));
      end
   end

   // Next-state logic for the IDLE/BUSY handshake FSM.
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // An ack seen in IDLE is stray and blocks the grant for that cycle.
            if (any_req_s && !q_m_ack) begin
               state_d     = ST_BUSY;
               grant_idx_d = win_s;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
               last_grant_d = win_s;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // Completion or abandonment both release the bus.
            if (q_m_ack || !m_access[grant_idx_q]) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, owner and fairness pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grant_idx_q <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_grant_q <= IW'(NUM_PORTS - 1);
`endif
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

endmodule
